// File: rtl/branch_sel_pkg.sv
// Shared types and sizing helpers for the branch select encoder.
// Optional violation counter is enabled with BRANCH_SEL_VIOL_CNT_EN.
package branch_sel_pkg;

  // Widest select index needed for the largest legal chain (16 branches + else).
  localparam int SEL_W_MAX = 5;

  typedef logic [SEL_W_MAX-1:0] sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  function automatic int sel_width(input int num_branch);
    return $clog2(num_branch + 1);
  endfunction

endpackage

// File: rtl/branch_sel_prio_enc.sv
// Combinational lowest-set-bit encoder with any-set and multi-set flags.
module branch_sel_prio_enc
  import branch_sel_pkg::*;
#(
  parameter int NUM_BRANCH = 4
) (
  input  logic [NUM_BRANCH-1:0] cond_i,
  output sel_t                  idx_o,
  output logic                  any_o,
  output logic                  multi_o
);

  localparam logic [NUM_BRANCH-1:0] ONE = NUM_BRANCH'(1);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_BRANCH - 1; i >= 0; i--) begin
      if (cond_i[i]) begin
        idx_o = sel_t'(i);
      end
    end
  end

  assign any_o   = |cond_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(cond_i & (cond_i - ONE));

endmodule

// File: rtl/branch_sel_encoder.sv
// Single-entry buffered encoder for if/else-if chains with violation flags.
// Define BRANCH_SEL_VIOL_CNT_EN to add the saturating violation counter.
module branch_sel_encoder
  import branch_sel_pkg::*;
#(
  parameter int NUM_BRANCH  = 4,
  parameter int UNIQUE_MODE = 0,
  parameter int CNT_W       = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_BRANCH-1:0]                 cond,
  input  logic                                  has_else,
`ifdef BRANCH_SEL_VIOL_CNT_EN
  input  logic                                  viol_clr,
  output logic [CNT_W-1:0]                      viol_count,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [sel_width(NUM_BRANCH)-1:0]      out_sel,
  output logic                                  out_else,
  output logic                                  out_none,
  output logic                                  out_multi
);

  localparam int SEL_W = sel_width(NUM_BRANCH);

  state_e           state_q;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             else_q, else_d;
  logic             none_q, none_d;
  logic             multi_q, multi_d;
  logic             accept;

  sel_t enc_idx;
  logic enc_any;
  logic enc_multi;

  branch_sel_prio_enc #(
    .NUM_BRANCH(NUM_BRANCH)
  ) u_prio_enc (
    .cond_i  (cond),
    .idx_o   (enc_idx),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  assign in_ready = !rst && ((state_q == IDLE) || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sel_d   = enc_any ? enc_idx[SEL_W-1:0] : SEL_W'(NUM_BRANCH);
    else_d  = !enc_any && has_else;
    none_d  = !enc_any && !has_else;
    multi_d = (UNIQUE_MODE != 0) && enc_multi;
  end

  // Results are only replaced on acceptance; a drained buffer keeps its last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      else_q  <= 1'b0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          if (out_ready && !in_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        sel_q   <= sel_d;
        else_q  <= else_d;
        none_q  <= none_d;
        multi_q <= multi_d;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_sel   = sel_q;
  assign out_else  = else_q;
  assign out_none  = none_q;
  assign out_multi = multi_q;

`ifdef BRANCH_SEL_VIOL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             viol_d;

  assign viol_d = accept && (none_d || multi_d);

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || viol_clr) begin
      cnt_q <= '0;
    end else if (viol_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign viol_count = cnt_q;
`endif

endmodule

// File: tb/tb_branch_sel_encoder.sv
// Directed bench driving a priority-mode and a unique-mode encoder in parallel.
// Counter checks are compiled in when BRANCH_SEL_VIOL_CNT_EN is defined.
module tb_branch_sel_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] cond;
  logic       has_else;
  logic       out_ready;
  logic       viol_clr;

  logic       pInReady, pValid, pElse, pNone, pMulti;
  logic [2:0] pSel;
  logic       uInReady, uValid, uElse, uNone, uMulti;
  logic [2:0] uSel;
`ifdef BRANCH_SEL_VIOL_CNT_EN
  logic [7:0] pCount;
  logic [1:0] uCount;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  branch_sel_encoder #(.NUM_BRANCH(4), .UNIQUE_MODE(0), .CNT_W(8)) dutP (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(pInReady),
    .cond(cond), .has_else(has_else),
`ifdef BRANCH_SEL_VIOL_CNT_EN
    .viol_clr(viol_clr), .viol_count(pCount),
`endif
    .out_valid(pValid), .out_ready(out_ready), .out_sel(pSel),
    .out_else(pElse), .out_none(pNone), .out_multi(pMulti)
  );

  branch_sel_encoder #(.NUM_BRANCH(4), .UNIQUE_MODE(1), .CNT_W(2)) dutU (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(uInReady),
    .cond(cond), .has_else(has_else),
`ifdef BRANCH_SEL_VIOL_CNT_EN
    .viol_clr(viol_clr), .viol_count(uCount),
`endif
    .out_valid(uValid), .out_ready(out_ready), .out_sel(uSel),
    .out_else(uElse), .out_none(uNone), .out_multi(uMulti)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic e,
                               input logic r);
    in_valid  = v;
    cond      = c;
    has_else  = e;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    viol_clr = 1'b0;
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_p_valid", pValid, 0);
    checkOutput("rst_p_sel", pSel, 0);
    checkOutput("rst_p_in_ready", pInReady, 0);
    checkOutput("rst_u_in_ready", uInReady, 0);
    checkOutput("rst_u_none", uNone, 0);
`ifdef BRANCH_SEL_VIOL_CNT_EN
    checkOutput("rst_u_count", uCount, 0);
`endif

    rst = 1'b0;
    applyStimulus(1'b1, 4'b0110, 1'b0, 1'b1);
    #1;
    checkOutput("idle_p_in_ready", pInReady, 1);
    tick();
    checkOutput("c0110_p_valid", pValid, 1);
    checkOutput("c0110_p_sel", pSel, 1);
    checkOutput("c0110_p_multi", pMulti, 0);
    checkOutput("c0110_p_none", pNone, 0);
    checkOutput("c0110_u_multi", uMulti, 1);
`ifdef BRANCH_SEL_VIOL_CNT_EN
    checkOutput("c0110_p_count", pCount, 0);
    checkOutput("c0110_u_count", uCount, 1);
`endif

    applyStimulus(1'b1, 4'b1010, 1'b0, 1'b1);
    tick();
    checkOutput("c1010_u_sel", uSel, 1);
    checkOutput("c1010_u_multi", uMulti, 1);
    checkOutput("c1010_p_multi", pMulti, 0);
`ifdef BRANCH_SEL_VIOL_CNT_EN
    checkOutput("c1010_u_count", uCount, 2);
`endif

    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    tick();
    checkOutput("else_p_sel", pSel, 4);
    checkOutput("else_p_else", pElse, 1);
    checkOutput("else_p_none", pNone, 0);
    checkOutput("else_u_multi", uMulti, 0);

    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("none_p_sel", pSel, 4);
    checkOutput("none_p_else", pElse, 0);
    checkOutput("none_p_none", pNone, 1);
`ifdef BRANCH_SEL_VIOL_CNT_EN
    checkOutput("none_p_count", pCount, 1);
    checkOutput("none_u_count", uCount, 3);
`endif

    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1);
    tick();
    checkOutput("c1000_p_sel", pSel, 3);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    #1;
    checkOutput("stall_p_in_ready", pInReady, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_p_valid", pValid, 1);
      checkOutput("stall_p_sel", pSel, 3);
      checkOutput("stall_u_in_ready", uInReady, 0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_p_in_ready", pInReady, 1);
    tick();
    checkOutput("release_p_valid", pValid, 1);
    checkOutput("release_p_sel", pSel, 0);

    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    tick();
`ifdef BRANCH_SEL_VIOL_CNT_EN
    checkOutput("sat_u_count", uCount, 3);
    checkOutput("sat_p_count", pCount, 3);
    viol_clr = 1'b1;
    tick();
    checkOutput("clr_u_count", uCount, 0);
    checkOutput("clr_p_count", pCount, 0);
    viol_clr = 1'b0;
`endif
    checkOutput("sat_u_none", uNone, 1);

    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b1);
    tick();
    checkOutput("drain_p_valid", pValid, 0);
    checkOutput("drain_p_sel_held", pSel, 4);
    tick();
    checkOutput("idle_hold_p_sel", pSel, 4);
`ifdef BRANCH_SEL_VIOL_CNT_EN
    checkOutput("idle_u_count", uCount, 0);
`endif

    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
    tick();
    checkOutput("full_p_sel", pSel, 2);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("rstfull_p_valid", pValid, 0);
    checkOutput("rstfull_p_sel", pSel, 0);
    checkOutput("rstfull_u_valid", uValid, 0);
    checkOutput("rstfull_p_else", pElse, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("postrst_p_valid", pValid, 0);
    checkOutput("postrst_u_sel", uSel, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
